hash_fold: RTL and testbench
============================

Name: hash_fold

Overview:
- Parametrised, multi-cycle key hashing engine. Next generation of the single-mode byte-sum hash unit.
- Folds a KEY_W-bit key into a HASH_W-bit value, WPC words per cycle, using a run-time selectable mode: end-around-carry sum, XOR fold, or CRC.
- Used by the match-table lookup path to derive bucket indices.
- Uses a level start/ready handshake: the result is held until the requester drops start.

Parameters:
KEY_W, 64, key width in bits; multiple of HASH_W*WPC, max 256
HASH_W, 8, hash width; legal values 8 or 16
WPC, 2, HASH_W-bit words consumed per RUN cycle; N = KEY_W/(HASH_W*WPC) RUN cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  level request; sampled only in IDLE
mode_i  in  2  0=SUM, 1=XOR, 2=CRC, 3=illegal; sampled with start_i
key_i  in  KEY_W  key; sampled with start_i
busy_o  out  1  high in RUN, FOLD1, FOLD2
hash_ready_o  out  1  result valid
hash_val_o  out  HASH_W  hash result
err_o  out  1  one-cycle pulse on illegal mode request

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: state=IDLE, busy_o=0, hash_ready_o=0, hash_val_o=0, err_o=0, accumulator=0. Reset mid-operation aborts immediately; no result is produced.
- Key words: word i = key_i[i*HASH_W +: HASH_W]. Processed lowest word first; WPC words per cycle, in ascending order within a cycle.
- IDLE:
  - start_i=1 and mode_i<3: latch key into a shift register, latch mode, clear accumulator, clear hash_ready_o, go to RUN.
  - start_i=1 and mode_i=3: pulse err_o for exactly one cycle, stay in IDLE, leave hash_ready_o unchanged. A held illegal request pulses again every 2 cycles (pulse, then one idle cycle).
  - hash_ready_o keeps its prior value in IDLE; it is cleared only by a new accepted start.
- RUN: N cycles; each consumes WPC words, then the shift register shifts right by HASH_W*WPC.
  - SUM: accumulator is HASH_W+8 bits wide; acc += zero-extended word. No overflow is possible within the parameter limits.
  - XOR: acc[HASH_W-1:0] ^= word.
  - CRC: MSB-first, non-reflected, init 0, no final XOR. Polynomial 0x07 for HASH_W=8, 0x1021 for HASH_W=16. Each word is fully absorbed per step (unrolled bitwise).
  - After the Nth RUN cycle, go to FOLD1.
- FOLD1: SUM mode: acc = acc[HASH_W-1:0] + (acc >> HASH_W) (end-around carry). Other modes: acc unchanged. Go to FOLD2.
- FOLD2: SUM mode: same fold again. Then hash_val_o <= acc[HASH_W-1:0] and hash_ready_o <= 1. Go to DONE.
- Latency: fixed for all modes. If start is accepted at edge 0, hash_ready_o and hash_val_o update at edge N+2 (default: edge 6).
- DONE: busy_o=0. Stays in DONE while start_i=1. When start_i=0, go to IDLE on that edge, still holding hash_ready_o and hash_val_o.
- start_i and mode_i changes during RUN/FOLD are ignored; a start_i drop mid-run does not abort.
- A new request needs a start_i low cycle seen in DONE, then start_i high in IDLE. Minimum back-to-back period is N+4 cycles.
- hash_val_o changes only at FOLD2 or reset.

Test Plan:
- SUM, key=0x0102030405060708, start held -> hash_ready_o rises at edge 6, hash_val_o=0x24; busy_o high for edges 1..6 (RUN, FOLD1, FOLD2).
- SUM, key=0xFFFFFFFFFFFFFFFF -> acc=0x7F8, FOLD1 gives 0xFF, FOLD2 gives 0xFF; hash_val_o=0xFF.
- XOR, key=0x0102030405060708 -> hash_val_o=0x08. Then CRC, key=0x0100000000000000 -> hash_val_o=0x07, both at the same latency.
- mode_i=3 with start_i=1 for one cycle -> err_o high one cycle, busy_o stays 0, previous hash_val_o and hash_ready_o unchanged.
- Accepted SUM start, rst pulsed at edge 3 -> all outputs 0. Next start with key=0x0102030405060708 -> hash_val_o=0x24 at edge 6.
- start_i dropped at edge 2 and re-raised at edge 3 -> the run is not restarted; result at edge 6; ready cleared only by the next accepted start (after start_i is seen low in DONE).

Source files
------------

// File: rtl/hash_fold.sv
// hash_fold: multi-cycle key hashing engine.
//
// Folds a KEY_W-bit key into a HASH_W-bit hash, consuming WPC HASH_W-bit
// words per RUN cycle (N = KEY_W / (HASH_W*WPC) RUN cycles). Three modes
// can be selected at run time: end-around-carry sum, XOR fold and CRC.
// The hash feeds bucket-index derivation in the match-table lookup path.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   start_i       level request, sampled only while idle
//   mode_i        0=SUM, 1=XOR, 2=CRC, 3=illegal (sampled with start_i)
//   key_i         key to hash (sampled with start_i)
//   busy_o        high while a hash is being computed
//   hash_ready_o  result valid; held until the next accepted request
//   hash_val_o    hash result
//   err_o         one-cycle pulse when an illegal mode is requested
//
// Handshake: the result stays in DONE while start_i is held high; the
// requester must drop start_i for at least one cycle before a new request
// can be accepted. Latency from acceptance to result is N+2 cycles.

module hash_fold #(
  parameter int KEY_W  = 64,
  parameter int HASH_W = 8,
  parameter int WPC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              busy_o,
  output logic              hash_ready_o,
  output logic [HASH_W-1:0] hash_val_o,
  output logic              err_o
);

  // Eight guard bits are enough to hold a SUM of up to 256 words without
  // overflow, which covers the largest legal key.
  localparam int ACC_W = HASH_W + 8;
  localparam int CHUNK = HASH_W * WPC;
  localparam int N     = KEY_W / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [15:0]       POLY_FULL = (HASH_W == 8) ? 16'h0007 : 16'h1021;
  localparam logic [HASH_W-1:0] POLY      = POLY_FULL[HASH_W-1:0];

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_XOR = 2'd1;
  localparam logic [1:0] MODE_CRC = 2'd2;
  localparam logic [1:0] MODE_ILL = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FOLD1,
    S_FOLD2,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [KEY_W-1:0]   r_shift;
  logic [1:0]         r_mode;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [HASH_W-1:0]  w_words [WPC];
  logic [ACC_W-1:0]   w_acc_run;
  logic [ACC_W-1:0]   w_acc_fold;

  // One full CRC step: the word is XORed into the register, then HASH_W
  // MSB-first shifts absorb it completely.
  function automatic logic [HASH_W-1:0] crc_step(input logic [HASH_W-1:0] crc_in,
                                                 input logic [HASH_W-1:0] word);
    logic [HASH_W-1:0] c;
    c = crc_in ^ word;
    for (int b = 0; b < HASH_W; b++) begin
      c = c[HASH_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  // The words for this cycle always sit at the bottom of the shift register.
  for (genvar gi = 0; gi < WPC; gi++) begin : g_word
    assign w_words[gi] = r_shift[gi*HASH_W +: HASH_W];
  end

  // Absorb the WPC words of this cycle in ascending order.
  always_comb begin
    w_acc_run = r_acc;
    for (int w = 0; w < WPC; w++) begin
      case (r_mode)
        MODE_SUM: w_acc_run = w_acc_run + ACC_W'(w_words[w]);
        MODE_XOR: w_acc_run[HASH_W-1:0] = w_acc_run[HASH_W-1:0] ^ w_words[w];
        MODE_CRC: w_acc_run[HASH_W-1:0] = crc_step(w_acc_run[HASH_W-1:0], w_words[w]);
        default:  w_acc_run = r_acc;
      endcase
    end
  end

  // End-around carry fold; two applications always bring the SUM
  // accumulator back into HASH_W bits. Other modes pass through.
  assign w_acc_fold = (r_mode == MODE_SUM)
                    ? (ACC_W'(r_acc[HASH_W-1:0]) + (r_acc >> HASH_W))
                    : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_mode       <= MODE_SUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      busy_o       <= 1'b0;
      hash_ready_o <= 1'b0;
      hash_val_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (mode_i != MODE_ILL) begin
              r_shift      <= key_i;
              r_mode       <= mode_i;
              r_acc        <= '0;
              r_cnt        <= '0;
              hash_ready_o <= 1'b0;
              busy_o       <= 1'b1;
              r_state      <= S_RUN;
            end else begin
              // A held illegal request alternates pulse / quiet cycle.
              err_o <= ~err_o;
            end
          end
        end

        S_RUN: begin
          r_acc   <= w_acc_run;
          r_shift <= r_shift >> CHUNK;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state <= S_FOLD1;
          end
        end

        S_FOLD1: begin
          r_acc   <= w_acc_fold;
          r_state <= S_FOLD2;
        end

        S_FOLD2: begin
          r_acc        <= w_acc_fold;
          hash_val_o   <= w_acc_fold[HASH_W-1:0];
          hash_ready_o <= 1'b1;
          busy_o       <= 1'b0;
          r_state      <= S_DONE;
        end

        S_DONE: begin
          // Result is held; leave only once the requester drops start_i.
          if (!start_i) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_fold.sv
// tb_hash_fold: self-checking bench for hash_fold.
// A transaction-level reference computes each hash from the key with plain
// arithmetic; a per-cycle timing model tracks when outputs must change.
// Directed scenarios are followed by a randomized phase.

module tb_hash_fold;

  localparam int KEY_W  = 64;
  localparam int HASH_W = 8;
  localparam int WPC    = 2;
  localparam int NW     = KEY_W / HASH_W;
  localparam int N      = KEY_W / (HASH_W * WPC);
  localparam int MASK   = (1 << HASH_W) - 1;
  localparam logic [HASH_W-1:0] POLY = 8'h07;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [1:0]        mode_i;
  logic [KEY_W-1:0]  key_i;
  logic              busy_o;
  logic              hash_ready_o;
  logic [HASH_W-1:0] hash_val_o;
  logic              err_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  hash_fold #(.KEY_W(KEY_W), .HASH_W(HASH_W), .WPC(WPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .hash_ready_o (hash_ready_o),
    .hash_val_o   (hash_val_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Hash of a whole key, straight from the mode definitions.
  function automatic logic [HASH_W-1:0] ref_hash(input logic [KEY_W-1:0] key,
                                                 input logic [1:0] mode);
    logic [HASH_W-1:0] w;
    logic [HASH_W-1:0] x;
    logic [HASH_W-1:0] c;
    int unsigned s;
    s = 0; x = '0; c = '0;
    for (int i = 0; i < NW; i++) begin
      w = key[i*HASH_W +: HASH_W];
      s = s + w;
      x = x ^ w;
      c = c ^ w;
      for (int b = 0; b < HASH_W; b++)
        c = c[HASH_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    for (int f = 0; f < 2; f++) s = (s & MASK) + (s >> HASH_W);
    case (mode)
      2'd0:    return s[HASH_W-1:0];
      2'd1:    return x;
      default: return c;
    endcase
  endfunction

  // Per-cycle expectation model and compare process.
  logic              m_busy, m_ready, m_err, m_done;
  logic [HASH_W-1:0] m_val, m_pending;
  int                m_cnt;

  initial begin
    logic prev_err;
    m_busy = 0; m_ready = 0; m_err = 0; m_done = 0; m_val = '0; m_pending = '0; m_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_busy = 0; m_ready = 0; m_err = 0; m_done = 0; m_val = '0; m_cnt = 0;
        chk_en = 1;
      end else if (chk_en) begin
        prev_err = m_err;
        m_err = 0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0; m_ready = 1; m_val = m_pending; m_done = 1;
          end
        end else if (m_done) begin
          if (!start_i) m_done = 0;
        end else if (start_i) begin
          if (mode_i != 2'd3) begin
            m_pending = ref_hash(key_i, mode_i);
            m_cnt = N + 2;
            m_busy = 1;
            m_ready = 0;
          end else begin
            m_err = !prev_err;
          end
        end
      end
      if (chk_en) begin
        check("cyc_busy",  32'(busy_o),       32'(m_busy));
        check("cyc_ready", 32'(hash_ready_o), 32'(m_ready));
        check("cyc_val",   32'(hash_val_o),   32'(m_val));
        check("cyc_err",   32'(err_o),        32'(m_err));
      end
    end
  end

  // Full handshake with per-cycle busy/ready checks and the final value.
  task automatic run(input logic [1:0] mode, input logic [KEY_W-1:0] key,
                     input logic [HASH_W-1:0] exp, input string name);
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; key_i = key;
    for (int k = 0; k <= N + 2; k++) begin
      @(negedge clk);
      check({name, "_busy"},  32'(busy_o),       32'(k <= N + 1));
      check({name, "_ready"}, 32'(hash_ready_o), 32'(k == N + 2));
    end
    check({name, "_val"}, 32'(hash_val_o), 32'(exp));
    start_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  localparam logic [KEY_W-1:0] KEY_A = 64'h0102030405060708;
  localparam logic [KEY_W-1:0] KEY_F = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [KEY_W-1:0] KEY_C = 64'h0100000000000000;

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 2'd0; key_i = '0;

    // Pin the reference model to hand-computed values.
    check("pin_sum",  32'(ref_hash(KEY_A, 2'd0)), 32'h24);
    check("pin_sumf", 32'(ref_hash(KEY_F, 2'd0)), 32'hFF);
    check("pin_xor",  32'(ref_hash(KEY_A, 2'd1)), 32'h08);
    check("pin_crc",  32'(ref_hash(KEY_C, 2'd2)), 32'h07);

    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_o),       32'h0);
    check("rst_ready", 32'(hash_ready_o), 32'h0);
    check("rst_val",   32'(hash_val_o),   32'h0);
    check("rst_err",   32'(err_o),        32'h0);
    rst = 1'b0;
    @(negedge clk);

    run(2'd0, KEY_A, 8'h24, "sum_a");
    run(2'd0, KEY_F, 8'hFF, "sum_f");
    run(2'd1, KEY_A, 8'h08, "xor_a");
    run(2'd2, KEY_C, 8'h07, "crc_c");

    // Illegal mode for one cycle: error pulse, previous result untouched.
    start_i = 1'b1; mode_i = 2'd3; key_i = KEY_A;
    @(negedge clk);
    check("ill_err",   32'(err_o),        32'h1);
    check("ill_busy",  32'(busy_o),       32'h0);
    check("ill_ready", 32'(hash_ready_o), 32'h1);
    check("ill_val",   32'(hash_val_o),   32'h07);
    start_i = 1'b0;
    @(negedge clk);
    check("ill_err_end", 32'(err_o), 32'h0);

    // Reset seen at edge 3 of an accepted SUM run aborts it.
    start_i = 1'b1; mode_i = 2'd0; key_i = KEY_A;
    repeat (3) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(busy_o),       32'h0);
    check("abort_ready", 32'(hash_ready_o), 32'h0);
    check("abort_val",   32'(hash_val_o),   32'h0);
    rst = 1'b0;
    @(negedge clk);
    run(2'd0, KEY_A, 8'h24, "after_rst");

    // start_i dropped at edge 2 and raised at edge 3: no restart.
    start_i = 1'b1; mode_i = 2'd0; key_i = KEY_A;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'd3; key_i = KEY_F;
    repeat (4) @(negedge clk);
    check("drop_ready", 32'(hash_ready_o), 32'h1);
    check("drop_val",   32'(hash_val_o),   32'h24);
    @(negedge clk);
    check("drop_hold",  32'(hash_ready_o), 32'h1);
    start_i = 1'b0; mode_i = 2'd1; key_i = KEY_A;
    @(negedge clk);
    check("drop_idle_ready", 32'(hash_ready_o), 32'h1);
    start_i = 1'b1;
    @(negedge clk);
    check("next_clr_ready", 32'(hash_ready_o), 32'h0);
    check("next_old_val",   32'(hash_val_o),   32'h24);
    repeat (N + 2) @(negedge clk);
    check("next_val", 32'(hash_val_o), 32'h08);
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      start_i = ($urandom_range(0, 3) != 0);
      mode_i  = 2'($urandom_range(0, 3));
      key_i   = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b0; start_i = 1'b0;
    repeat (N + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
